// File: rtl/arith_addsubi_pipe_pkg.sv
// ---------------------------------------------------------------------------
// arith_pkg : shared types and flag indices for the add/sub pipeline
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package arith_pkg;

  typedef enum logic [1:0] {
    ADD     = 2'd0,
    SUB     = 2'd1,
    ADD_SAT = 2'd2,
    SUB_SAT = 2'd3
  } arith_addsub_op_e;

  localparam int unsigned FLAG_CARRY = 0;
  localparam int unsigned FLAG_OVF   = 1;
  localparam int unsigned FLAG_ZERO  = 2;
  localparam int unsigned FLAG_W     = 3;

endpackage

`default_nettype wire

// File: rtl/arith_pipe_stage.sv
// ---------------------------------------------------------------------------
// arith_pipe_stage : single elastic valid/ready register slice
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module arith_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         stage_valid;
  logic [W-1:0] stage_data;

  // An empty slot accepts regardless of downstream, so bubbles collapse.
  assign in_ready  = ~stage_valid | out_ready;
  assign out_valid = stage_valid;
  assign out_data  = stage_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= 1'b0;
      stage_data  <= '0;
    end else if (in_ready) begin
      stage_valid <= in_valid;
      if (in_valid) begin
        stage_data <= in_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/arith_addsubi_pipe.sv
// ---------------------------------------------------------------------------
// arith_addsubi_pipe : elastic pipelined add/sub with optional saturation
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module arith_addsubi_pipe
  import arith_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [1:0]       op_data,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result_data,
  output logic [2:0]       result_flags
);

  localparam int SW = WIDTH + FLAG_W;

  arith_addsub_op_e  op;
  logic              is_sub;
  logic              is_sat;
  logic [WIDTH-1:0]  b_eff;
  logic [WIDTH:0]    raw;
  logic [WIDTH-1:0]  sum;
  logic [WIDTH-1:0]  clamp;
  logic [WIDTH-1:0]  final_res;
  logic              carry;
  logic              ovf;
  logic [FLAG_W-1:0] flags;
  logic              in_ready;
  logic              fire;

  assign op = arith_addsub_op_e'(op_data);

  always_comb begin
    is_sub    = (op == SUB) || (op == SUB_SAT);
    is_sat    = (op == ADD_SAT) || (op == SUB_SAT);
    b_eff     = is_sub ? ~b_data : b_data;
    raw       = {1'b0, a_data} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    sum       = raw[WIDTH-1:0];
    // Subtract reports borrow, which is the inverse of the adder carry-out.
    carry     = is_sub ? ~raw[WIDTH] : raw[WIDTH];
    ovf       = (a_data[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_data[WIDTH-1]);
    clamp     = a_data[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    final_res = (is_sat && ovf) ? clamp : sum;
    flags             = '0;
    flags[FLAG_CARRY] = carry;
    flags[FLAG_OVF]   = ovf;
    flags[FLAG_ZERO]  = (final_res == '0);
  end

  // Readies are held low while reset is asserted.
  assign in_ready = rst_n & g_stage[0].s_in_ready;
  assign fire     = a_valid & b_valid & op_valid & in_ready;
  assign a_ready  = in_ready & b_valid & op_valid;
  assign b_ready  = in_ready & a_valid & op_valid;
  assign op_ready = in_ready & a_valid & b_valid;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic          s_in_valid;
    logic          s_in_ready;
    logic [SW-1:0] s_in_data;
    logic          s_out_valid;
    logic          s_out_ready;
    logic [SW-1:0] s_out_data;

    if (i == 0) begin : g_first
      assign s_in_valid = fire;
      assign s_in_data  = {final_res, flags};
    end else begin : g_chain
      assign s_in_valid = g_stage[i-1].s_out_valid;
      assign s_in_data  = g_stage[i-1].s_out_data;
    end

    if (i == STAGES - 1) begin : g_last
      assign s_out_ready = result_ready;
    end else begin : g_link
      assign s_out_ready = g_stage[i+1].s_in_ready;
    end

    arith_pipe_stage #(
      .W (SW)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .in_data   (s_in_data),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready),
      .out_data  (s_out_data)
    );
  end

  assign result_valid = g_stage[STAGES-1].s_out_valid;
  assign result_data  = g_stage[STAGES-1].s_out_data[SW-1:FLAG_W];
  assign result_flags = g_stage[STAGES-1].s_out_data[FLAG_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_arith_addsubi_pipe.sv
// ---------------------------------------------------------------------------
// tb_arith_addsubi_pipe : directed scoreboard bench, WIDTH=8 STAGES=2
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_arith_addsubi_pipe;

  localparam int WIDTH  = 8;
  localparam int STAGES = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             a_valid = 1'b0, b_valid = 1'b0, op_valid = 1'b0;
  logic             a_ready, b_ready, op_ready;
  logic [WIDTH-1:0] a_data = '0, b_data = '0;
  logic [1:0]       op_data = '0;
  logic             result_valid;
  logic             result_ready = 1'b1;
  logic [WIDTH-1:0] result_data;
  logic [2:0]       result_flags;

  always #5 clk = ~clk;

  arith_addsubi_pipe #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .a_valid      (a_valid),
    .a_ready      (a_ready),
    .a_data       (a_data),
    .b_valid      (b_valid),
    .b_ready      (b_ready),
    .b_data       (b_data),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_data      (op_data),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_data  (result_data),
    .result_flags (result_flags)
  );

  logic [10:0] sb[$];
  logic [10:0] exp_t;
  int          total_cnt = 0;
  int          pass_cnt  = 0;
  int          pops      = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model in plain signed/unsigned integer arithmetic: {res, zero, ovf, carry}.
  function automatic logic [10:0] model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int         sa, sbv, r;
    logic [7:0] res;
    logic       c, v;
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    if (op[0]) begin
      r = sa - sbv;
      c = (a < b);
    end else begin
      r = sa + sbv;
      c = ((int'(a) + int'(b)) > 255);
    end
    v   = (r > 127) || (r < -128);
    res = r[7:0];
    if (op[1] && v) res = (r > 127) ? 8'h7F : 8'h80;
    return {res, (res == 8'h00), v, c};
  endfunction

  always @(negedge clk) begin
    if (rst_n && result_valid && result_ready) begin
      pops++;
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t = sb.pop_front();
        chk("result_data", 32'(result_data), 32'(exp_t[10:3]));
        chk("result_flags", 32'(result_flags), 32'(exp_t[2:0]));
      end
    end
  end

  task automatic drive(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    a_valid = 1'b1; b_valid = 1'b1; op_valid = 1'b1;
    a_data = a; b_data = b; op_data = op;
  endtask

  task automatic idle();
    a_valid = 1'b0; b_valid = 1'b0; op_valid = 1'b0;
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    drive(op, a, b);
    @(negedge clk);
    while (!a_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept", 32'(a_ready), 32'd1);
    if (a_ready) sb.push_back(model(op, a, b));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  logic [1:0] bp_op[4] = '{2'd0, 2'd1, 2'd2, 2'd3};
  logic [7:0] bp_a[4]  = '{8'h10, 8'h20, 8'h70, 8'hC0};
  logic [7:0] bp_b[4]  = '{8'h05, 8'h30, 8'h40, 8'h50};

  initial begin
    int idx;
    int pops0;

    // Readies must stay low in reset even with every valid asserted.
    drive(2'd0, 8'h12, 8'h34);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result_valid", 32'(result_valid), 32'd0);
    chk("rst_result_data", 32'(result_data), 32'd0);
    chk("rst_result_flags", 32'(result_flags), 32'd0);
    chk("rst_a_ready", 32'(a_ready), 32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd0);
    chk("rst_op_ready", 32'(op_ready), 32'd0);
    idle();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency: fire at edge N, result visible after edge N+1.
    send(2'd0, 8'h7F, 8'h01);
    idle();
    chk("lat_not_yet", 32'(result_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_valid", 32'(result_valid), 32'd1);
    chk("lat_data", 32'(result_data), 32'h80);
    chk("lat_flags", 32'(result_flags), 32'b010);
    drain();

    // Directed corner cases, back to back.
    send(2'd2, 8'h7F, 8'h01);
    send(2'd0, 8'hFF, 8'h01);
    send(2'd1, 8'h00, 8'h01);
    send(2'd3, 8'h80, 8'h01);
    send(2'd1, 8'h05, 8'h05);
    send(2'd2, 8'h80, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      send(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
    end
    idle();
    drain();

    // Backpressure: only STAGES tokens fit while the result side stalls.
    result_ready = 1'b0;
    idx = 0;
    drive(bp_op[0], bp_a[0], bp_b[0]);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (a_ready) begin
        sb.push_back(model(bp_op[idx], bp_a[idx], bp_b[idx]));
        idx++;
      end
      @(posedge clk); #1;
      if (idx < 4) drive(bp_op[idx], bp_a[idx], bp_b[idx]);
    end
    chk("bp_accepted", 32'(idx), 32'd2);
    chk("bp_a_ready", 32'(a_ready), 32'd0);
    chk("bp_b_ready", 32'(b_ready), 32'd0);
    chk("bp_op_ready", 32'(op_ready), 32'd0);
    chk("bp_hold_valid", 32'(result_valid), 32'd1);
    chk("bp_hold_data", 32'(result_data), 32'(sb[0][10:3]));
    result_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("bp_stream_valid", 32'(result_valid), 32'd1);
      if (a_valid && a_ready && idx < 4) begin
        sb.push_back(model(bp_op[idx], bp_a[idx], bp_b[idx]));
        idx++;
      end
      @(posedge clk); #1;
      if (idx < 4) drive(bp_op[idx], bp_a[idx], bp_b[idx]);
      else idle();
    end
    chk("bp_all_fired", 32'(idx), 32'd4);
    drain();

    // Partial join: B missing holds everything, then fires exactly once.
    pops0 = pops;
    drive(2'd0, 8'h33, 8'h44);
    b_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("pj_b_ready", 32'(b_ready), 32'd1);
      chk("pj_a_ready", 32'(a_ready), 32'd0);
      chk("pj_op_ready", 32'(op_ready), 32'd0);
      chk("pj_no_result", 32'(result_valid), 32'd0);
      @(posedge clk); #1;
    end
    b_valid = 1'b1;
    @(negedge clk);
    chk("pj_fire", 32'(b_ready), 32'd1);
    if (b_ready) sb.push_back(model(2'd0, 8'h33, 8'h44));
    @(posedge clk); #1;
    idle();
    repeat (4) @(posedge clk);
    #1;
    drain();
    chk("pj_single", 32'(pops - pops0), 32'd1);

    // Reset with two tokens in flight.
    result_ready = 1'b0;
    send(2'd0, 8'h01, 8'h02);
    send(2'd1, 8'h09, 8'h03);
    idle();
    chk("rmid_pre_valid", 32'(result_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rmid_valid", 32'(result_valid), 32'd0);
    chk("rmid_data", 32'(result_data), 32'd0);
    chk("rmid_flags", 32'(result_flags), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    result_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("rmid_no_stale", 32'(result_valid), 32'd0);
      @(posedge clk); #1;
    end

    // Pipeline still functional after reset.
    send(2'd3, 8'h7F, 8'hFF);
    idle();
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
